// File: rtl/mem_stream_pkg.sv
// Shared types and default widths for the memory stream reader.
package mem_stream_pkg;
    localparam int DEF_ADDR_W     = 24;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_RAM_AW     = 19;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; push while full and pop while empty are dropped.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) count_d = count_q + (PW+1)'(1);
        if (do_pop && !do_push) count_d = count_q - (PW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/mem_stream_reader.sv
// Burst reader: issues credit-limited reads to a 1-cycle-latency RAM and
// streams the returned words through a small FIFO with a last marker.
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RAM_AW     = DEF_RAM_AW,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [RAM_AW-1:0] length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_writeenable,
    output logic [ADDR_W-1:0] mem_writedata,
    input  logic [ADDR_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output state_t            dbg_state_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [RAM_AW-1:0] base_q, len_q, issued_q;
    logic              outstanding_q, rd_last_q;
    logic [RAM_AW-1:0] ram_addr;
    logic              issue_last, credit_ok, pop;
    logic [CW:0]       inflight;
    logic [DATA_W:0]   fifo_dout;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              unused_bits;

    assign ram_addr   = base_q + issued_q;
    assign issue_last = (issued_q == len_q - RAM_AW'(1));
    // A read in flight already owns a FIFO slot, so it counts against the credit.
    assign inflight   = {1'b0, fifo_count} + {{CW{1'b0}}, outstanding_q};
    assign credit_ok  = (inflight < (CW+1)'(FIFO_DEPTH));
    assign pop        = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        mem_read = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (length != '0) ? ISSUE : FINISH;
            end
            ISSUE: begin
                busy     = 1'b1;
                mem_read = credit_ok;
                if (credit_ok && issue_last) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && fifo_dout[DATA_W]) state_d = FINISH;
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            base_q        <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            outstanding_q <= 1'b0;
            rd_last_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= mem_read;
            rd_last_q     <= mem_read & issue_last;
            if (state_q == IDLE && start) begin
                base_q   <= base_addr[RAM_AW-1:0];
                len_q    <= length;
                issued_q <= '0;
            end else if (mem_read) begin
                issued_q <= issued_q + RAM_AW'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (outstanding_q),
        .pop   (pop),
        .din   ({rd_last_q, mem_data[DATA_W-1:0]}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign mem_address     = (state_q == ISSUE) ? ADDR_W'(ram_addr) : '0;
    assign mem_writeenable = 1'b0;
    assign mem_writedata   = '0;
    assign out_valid       = ~fifo_empty;
    assign out_data        = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
    assign out_last        = ~fifo_empty & fifo_dout[DATA_W];
    assign dbg_state_o     = state_q;
    assign unused_bits     = ^{base_addr[ADDR_W-1:RAM_AW], mem_data[ADDR_W-1:DATA_W], fifo_full};
endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 Parameter ADDR_W, default 24, width of memory address and data buses.
REQ-002 Parameter DATA_W, default 16, payload width returned by the data RAM.
REQ-003 Parameter RAM_AW, default 19, implemented RAM address width.
REQ-004 Parameter FIFO_DEPTH, default 4, output buffer entries; power of two, at least 2.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-008 base_addr  input  ADDR_W  first word address, captured on an accepted start.
REQ-009 length  input  RAM_AW  word count, captured on an accepted start; 0 is legal.
REQ-010 busy  output  1  high from the cycle after an accepted start until done.
REQ-011 done  output  1  one-cycle pulse at burst completion.
REQ-012 mem_address  output  ADDR_W  read address to data memory.
REQ-013 mem_read  output  1  read strobe to data memory.
REQ-014 mem_writeenable  output  1  constant 0.
REQ-015 mem_writedata  output  ADDR_W  constant 0.
REQ-016 mem_data  input  ADDR_W  read data from data memory; only bits [DATA_W-1:0] are used.
REQ-017 out_valid  output  1  out_data holds a word.
REQ-018 out_ready  input  1  consumer accepts the word when high with out_valid.
REQ-019 out_data  output  DATA_W  streamed word.
REQ-020 out_last  output  1  high with the final word of a burst.

Function
REQ-021 The FSM SHALL have the states IDLE, ISSUE, DRAIN and FINISH.
REQ-022 IDLE: start=1 with length>0 SHALL capture the inputs and enter ISSUE; start=1 with length=0 SHALL enter FINISH without any read.
REQ-023 ISSUE: mem_read=1 only when outstanding reads plus FIFO occupancy is less than FIFO_DEPTH; otherwise mem_read=0 and the address holds.
REQ-024 mem_address[RAM_AW-1:0] SHALL be base_addr[RAM_AW-1:0] plus the issued-word count, modulo 2^RAM_AW; bits above RAM_AW-1 SHALL be 0.
REQ-025 Read latency SHALL be exactly 1 cycle: a read issued in cycle N returns valid mem_data in cycle N+1, and the block SHALL write it into the FIFO at the end of N+1.
REQ-026 After the length-th issue, the FSM SHALL go to DRAIN; DRAIN SHALL exit to FINISH in the cycle after the last word is accepted (out_valid & out_ready).
REQ-027 FINISH SHALL last one cycle, assert done=1 and busy=0, then return to IDLE.
REQ-028 out_valid SHALL equal FIFO non-empty; out_data and out_last SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 out_last SHALL mark only the word with index length-1.
REQ-030 A simultaneous FIFO push and pop SHALL leave occupancy unchanged; the FIFO SHALL never overflow, which the credit rule of REQ-023 guarantees.
REQ-031 The block SHALL ignore start while busy=1 or done=1.
REQ-032 Address wrap from 2^RAM_AW-1 to 0 within a burst SHALL be silent and legal.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE, empty the FIFO, clear the counters and outstanding flag, and drive busy=0, done=0, mem_read=0, mem_address=0, out_valid=0, out_last=0, out_data=0.
REQ-034 A reset during a burst SHALL abort it; no done pulse and no further words SHALL follow.

Structure
REQ-035 The FSM state enum and the ADDR_W, DATA_W and RAM_AW defaults SHALL live in the shared package mem_stream_pkg.
REQ-036 The output buffer SHALL be a sub-module, sync_fifo (parameters width and depth; push, pop, full, empty, count), instantiated once with width DATA_W+1 to carry last.

Verification
REQ-037 base=0x000010, length=4, out_ready=1 -> reads at 0x10..0x13 on consecutive cycles; out_data=mem[0x10..0x13]; out_last on the 4th word; done one cycle after it.
REQ-038 length=0 -> no mem_read; done pulses 1 cycle after start; busy never asserted.
REQ-039 base=0x07FFFE, length=4 -> mem_address sequence 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
REQ-040 length=10, out_ready held 0 -> exactly FIFO_DEPTH reads are issued, then mem_read=0; releasing out_ready delivers all 10 words in order with none lost or duplicated.
REQ-041 rst_n=0 for one cycle after the 3rd word of a length-8 burst -> all outputs at their reset values next cycle; no done; a new start then runs normally.
REQ-042 A start pulse while busy=1 -> ignored; the current burst completes unchanged.
